// File: rtl/gate_bist_if.sv
// Stimulus/response bundle between the gate bank tester and its environment.
// start is a level request: it is taken on any rising edge where the tester is not busy, and ignored while busy.
interface gate_bist_if;
  logic       start;
  logic [6:0] y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_mask;
  logic [2:0] err_cnt;

  modport slave (
    input  start, y,
    output a, b, busy, done, pass, fail_mask, err_cnt
  );

  modport master (
    output start, y,
    input  a, b, busy, done, pass, fail_mask, err_cnt
  );
endinterface

// File: rtl/gate_bist.sv
// Built-in self-test for the seven-gate bank: walks {a,b} through 00..11,
// samples y after HOLD cycles per vector, and accumulates a sticky fail mask and error count.
module gate_bist #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  gate_bist_if.slave bus,
  output logic [1:0] dbg_state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] hold_q, hold_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [6:0] fail_q, fail_d;
  logic [2:0] err_q, err_d;
  logic [6:0] mism;

  // Bit order: [6] not(a), [5] xor, [4] xnor, [3] nor, [2] nand, [1] or, [0] and.
  function automatic logic [6:0] expected(input logic ea, input logic eb);
    return {~ea, ea ^ eb, ~(ea ^ eb), ~(ea | eb), ~(ea & eb), ea | eb, ea & eb};
  endfunction

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    err_d   = err_q;
    mism    = bus.y ^ expected(a_q, b_q);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = APPLY;
          vec_d   = 2'd0;
          hold_d  = 8'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 7'd0;
          err_d   = 3'd0;
        end
      end
      APPLY: begin
        if (hold_q == HOLD_LAST) begin
          fail_d = fail_q | mism;
          if (mism != 7'd0) err_d = err_q + 3'd1;
          hold_d = 8'd0;
          if (vec_q == 2'd3) begin
            state_d = DONE;
            vec_d   = 2'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // pass is registered alongside done so both change on the same edge.
    pass_d = done_d && (fail_d == 7'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      hold_q  <= 8'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 7'd0;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_q;
  assign bus.err_cnt   = err_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: two instances (HOLD=2 and HOLD=1) share stimulus and a fault-injectable gate bank,
// and are checked every cycle against a time-based run model plus directed scenario checks.
module tb_gate_bist;
  localparam int H0 = 2;
  localparam int H1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [6:0] sa0 = 7'd0;
  logic [6:0] flip = 7'd0;
  logic [1:0] dbg0, dbg1;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  gate_bist_if bus0 ();
  gate_bist_if bus1 ();

  gate_bist #(.HOLD(H0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0));
  gate_bist #(.HOLD(H1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1));

  function automatic logic [6:0] good(input logic [1:0] ab);
    logic ga, gb;
    ga = ab[1];
    gb = ab[0];
    return {~ga, ga ^ gb, ~(ga ^ gb), ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
  endfunction

  function automatic logic [6:0] bank(input logic [1:0] ab);
    return (good(ab) & ~sa0) ^ flip;
  endfunction

  assign bus0.start = start;
  assign bus1.start = start;
  assign bus0.y     = bank({bus0.a, bus0.b});
  assign bus1.y     = bank({bus1.a, bus1.b});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run model: mode 0 idle, 1 running, 2 done; t counts cycles since the accepting edge.
  int         hold_v[2] = '{H0, H1};
  int         m_mode[2] = '{0, 0};
  int         m_t[2]    = '{0, 0};
  int         m_err[2]  = '{0, 0};
  logic [6:0] m_fail[2] = '{7'd0, 7'd0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0;
        m_t[i]    <= 0;
        m_err[i]  <= 0;
        m_fail[i] <= 7'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int         mode = m_mode[i];
        automatic int         t    = m_t[i];
        automatic int         err  = m_err[i];
        automatic logic [6:0] fl   = m_fail[i];
        automatic logic [6:0] mm;
        automatic logic [1:0] k;
        if (mode != 1 && start) begin
          mode = 1; t = 0; fl = 7'd0; err = 0;
        end else if (mode == 1) begin
          if ((t + 1) % hold_v[i] == 0) begin
            k  = 2'(t / hold_v[i]);
            mm = bank(k) ^ good(k);
            fl = fl | mm;
            if (mm != 7'd0) err++;
          end
          t++;
          if (t == 4 * hold_v[i]) mode = 2;
        end
        m_mode[i] <= mode;
        m_t[i]    <= t;
        m_err[i]  <= err;
        m_fail[i] <= fl;
      end
    end
  end

  function automatic logic [14:0] model_out(input int i);
    logic [1:0] ab;
    logic       dn;
    ab = (m_mode[i] == 1) ? 2'(m_t[i] / hold_v[i]) : 2'd0;
    dn = (m_mode[i] == 2);
    return {ab, m_mode[i] == 1, dn, dn && (m_fail[i] == 7'd0), m_fail[i], 3'(m_err[i])};
  endfunction

  always @(negedge clk) begin
    chk("cycle_h2", {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.fail_mask, bus0.err_cnt},
        model_out(0));
    chk("cycle_h1", {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.fail_mask, bus1.err_cnt},
        model_out(1));
  end

  task automatic pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus0.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("done_timeout", 32'(n), 32'd0);
  endtask

  int n, nb;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs0", {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.fail_mask, bus0.err_cnt}, 0);
    chk("reset_outs1", {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.fail_mask, bus1.err_cnt}, 0);
    chk("reset_state0", dbg0, 0);
    rst_n = 1'b1;

    chk("truth_00", good(2'b00), 7'b1011100);
    chk("truth_01", good(2'b01), 7'b1100110);
    chk("truth_10", good(2'b10), 7'b0100110);
    chk("truth_11", good(2'b11), 7'b0010011);

    // Fault-free run
    pulse();
    chk("vec0_ab", {bus0.a, bus0.b, bus0.busy}, 3'b001);
    wait_done(n);
    chk("done_latency", n, 8);
    chk("ff_pass", bus0.pass, 1);
    chk("ff_fail", bus0.fail_mask, 0);
    chk("ff_err", bus0.err_cnt, 0);

    // and stuck at 0
    sa0 = 7'b0000001;
    pulse();
    wait_done(n);
    chk("sa0_fail", bus0.fail_mask, 7'b0000001);
    chk("sa0_err", bus0.err_cnt, 1);
    chk("sa0_pass", bus0.pass, 0);
    chk("sa0_fail_h1", bus1.fail_mask, 7'b0000001);

    // not(a) inverted
    sa0 = 7'd0;
    flip = 7'b1000000;
    pulse();
    wait_done(n);
    chk("inv_fail", bus0.fail_mask, 7'b1000000);
    chk("inv_err", bus0.err_cnt, 4);
    chk("inv_err_h1", bus1.err_cnt, 4);

    // Restart from DONE after a failing run
    flip = 7'd0;
    pulse();
    chk("restart_clear", {bus0.done, bus0.fail_mask, bus0.err_cnt}, 0);
    wait_done(n);
    chk("restart_pass", bus0.pass, 1);

    // start during vector 01 ignored, then reset during vector 10
    pulse();
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignored_start_ab", {bus0.a, bus0.b}, 2'b01);
    @(posedge clk);
    #1;
    chk("vec10_ab", {bus0.a, bus0.b}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset", {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.fail_mask, bus0.err_cnt}, 0);
    chk("midrun_state", dbg0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse();
    wait_done(n);
    chk("after_reset_n", n, 8);
    chk("after_reset_pass", bus0.pass, 1);

    // HOLD=1 with start held high
    flip = 7'b1000000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus1.busy) nb++;
      @(posedge clk);
      #1;
    end
    chk("h1_busy_cycles", nb, 4);
    chk("h1_done", {bus1.busy, bus1.done, bus1.fail_mask, bus1.err_cnt}, {2'b01, 7'b1000000, 3'd4});
    @(posedge clk);
    #1;
    chk("h1_restart", {bus1.busy, bus1.done, bus1.fail_mask, bus1.err_cnt}, {2'b10, 7'd0, 3'd0});
    @(negedge clk);
    start = 1'b0;
    flip = 7'd0;
    repeat (20) @(negedge clk);

    // Randomized traffic, faults and occasional async reset
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        sa0  = $urandom_range(0, 1) ? 7'($urandom_range(0, 127)) : 7'd0;
        flip = $urandom_range(0, 1) ? 7'($urandom_range(0, 127)) : 7'd0;
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
